// File: rtl/gray_pkg.sv
// Shared Gray-code constants and WIDTH-generic conversion helpers.
// Callers zero-extend narrower values to the full word and truncate the result.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 shift stages.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int s = 1; s < GRAY_MAX_WIDTH; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror and terminal-count flag.
// Optional wrap-around or saturation at the bounds; synchronous load and reset.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
    $error("gray_counter: WIDTH must be in 2..%0d", GRAY_MAX_WIDTH);
  end

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_tc;

  logic [WIDTH-1:0] w_bin_step;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_at_bound;
  logic             w_tc_next;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_bin_next = r_bin;
    w_tc_next  = 1'b0;
    w_at_bound = up_dn ? (r_bin == BIN_MAX) : (r_bin == '0);
    w_bin_step = up_dn ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));

    if (load) begin
      w_bin_next = load_bin;
    end else if (en) begin
      // A step that crosses a bound flags tc whether it wraps or is blocked.
      w_tc_next = w_at_bound;
      if (WRAP || !w_at_bound) begin
        w_bin_next = w_bin_step;
      end
    end
  end

  // Gray is derived from the same next value as bin so the pair never disagrees.
  assign w_gray_next = WIDTH'(bin2gray(gray_word_t'(w_bin_next)));

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; sequential state uses non-blocking assignments.
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_tc   <= w_tc_next;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign tc   = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed corner cases on 4-bit wrap/saturate
// instances plus randomized traffic against an arithmetic reference model.
module tb_gray_counter;
  import gray_pkg::*;

  logic clk;

  // 4-bit instances share one set of inputs.
  logic       rst4, en4, up4, ld4;
  logic [3:0] lb4;
  logic [3:0] bin_w, gray_w, bin_s, gray_s;
  logic       tc_w, tc_s;

  logic       rst8, en8, up8, ld8;
  logic [7:0] lb8;
  logic [7:0] bin_8, gray_8;
  logic       tc_8;

  int n_checks = 0;
  int n_pass   = 0;

  int m_w = 0, m_s = 0, m_8 = 0;
  bit t_w = 0, t_s = 0, t_8 = 0;

  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_dut_wrap (
    .clk(clk), .rst(rst4), .en(en4), .up_dn(up4), .load(ld4), .load_bin(lb4),
    .bin(bin_w), .gray(gray_w), .tc(tc_w)
  );

  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_dut_sat (
    .clk(clk), .rst(rst4), .en(en4), .up_dn(up4), .load(ld4), .load_bin(lb4),
    .bin(bin_s), .gray(gray_s), .tc(tc_s)
  );

  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_dut_w8 (
    .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .load(ld8), .load_bin(lb8),
    .bin(bin_8), .gray(gray_8), .tc(tc_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Counter behaviour as plain integer arithmetic on the range 0..2^w-1.
  function automatic void model_step(inout int m, inout bit t, input int w, input bit wrap,
                                     input bit r, input bit l, input int lb,
                                     input bit e, input bit u);
    int span;
    int n;
    span = 1 << w;
    t = 1'b0;
    if (r) m = 0;
    else if (l) m = lb;
    else if (e) begin
      n = u ? m + 1 : m - 1;
      if (n >= span || n < 0) begin
        t = 1'b1;
        if (wrap) m = (n + span) % span;
      end else begin
        m = n;
      end
    end
  endfunction

  task automatic tick4(input bit r, input bit l, input logic [3:0] lb, input bit e, input bit u);
    @(negedge clk);
    rst4 = r; ld4 = l; lb4 = lb; en4 = e; up4 = u;
    @(posedge clk);
    #1;
    model_step(m_w, t_w, 4, 1'b1, r, l, int'(lb), e, u);
    model_step(m_s, t_s, 4, 1'b0, r, l, int'(lb), e, u);
    check("wrap_bin", bin_w, m_w);
    check("wrap_g2b", gray2bin(gray_word_t'(gray_w)), m_w);
    check("wrap_tc",  tc_w, t_w);
    check("sat_bin",  bin_s, m_s);
    check("sat_g2b",  gray2bin(gray_word_t'(gray_s)), m_s);
    check("sat_tc",   tc_s, t_s);
  endtask

  task automatic tick8(input bit r, input bit l, input logic [7:0] lb, input bit e, input bit u);
    logic [7:0] prev_gray;
    prev_gray = gray_8;
    @(negedge clk);
    rst8 = r; ld8 = l; lb8 = lb; en8 = e; up8 = u;
    @(posedge clk);
    #1;
    model_step(m_8, t_8, 8, 1'b1, r, l, int'(lb), e, u);
    check("w8_bin", bin_8, m_8);
    check("w8_g2b", gray2bin(gray_word_t'(gray_8)), m_8);
    check("w8_tc",  tc_8, t_8);
    if (!r && !l && e) check("w8_hamming", $countones(prev_gray ^ gray_8), 1);
  endtask

  initial begin
    rst4 = 1'b1; ld4 = 1'b0; lb4 = '0; en4 = 1'b0; up4 = 1'b1;
    rst8 = 1'b1; ld8 = 1'b0; lb8 = '0; en8 = 1'b0; up8 = 1'b1;

    tick4(1, 0, 4'h0, 0, 0);
    check("reset_gray", gray_w, 0);

    // Full up-count cycle through the Gray sequence and the wrap.
    for (int k = 1; k <= 16; k++) begin
      tick4(0, 0, 4'h0, 1, 1);
      check("seq_gray", gray_w, gray_tbl[k % 16]);
      check("seq_tc", tc_w, (k == 16) ? 1 : 0);
    end
    tick4(0, 0, 4'h0, 0, 1);
    check("post_wrap_tc", tc_w, 0);
    check("post_wrap_gray", gray_w, 0);

    // Load beats enable.
    tick4(0, 1, 4'hA, 1, 1);
    check("load_bin", bin_w, 32'hA);
    check("load_gray", gray_w, 32'hF);
    check("load_tc", tc_w, 0);

    // Down-wrap from zero.
    tick4(1, 0, 4'h0, 0, 0);
    tick4(0, 0, 4'h0, 1, 0);
    check("dnwrap_bin", bin_w, 32'hF);
    check("dnwrap_gray", gray_w, 32'h8);
    check("dnwrap_tc", tc_w, 1);
    tick4(0, 0, 4'h0, 1, 0);
    check("dn2_bin", bin_w, 32'hE);
    check("dn2_gray", gray_w, 32'h9);
    check("dn2_tc", tc_w, 0);

    // Saturation at the top bound.
    tick4(0, 1, 4'hF, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick4(0, 0, 4'h0, 1, 1);
      check("sat_hold_bin", bin_s, 32'hF);
      check("sat_hold_gray", gray_s, 32'h8);
      check("sat_hold_tc", tc_s, 1);
    end
    tick4(0, 0, 4'h0, 1, 0);
    check("sat_down_bin", bin_s, 32'hE);
    check("sat_down_tc", tc_s, 0);

    // Reset overrides a simultaneous load and enable, then holds while idle.
    tick4(1, 1, 4'h5, 1, 1);
    check("rst_ovr_bin", bin_w, 0);
    check("rst_ovr_gray", gray_w, 0);
    check("rst_ovr_tc", tc_w, 0);
    for (int k = 0; k < 4; k++) begin
      tick4(0, 0, 4'(k), 0, 1'($urandom));
      check("idle_bin", bin_w, 0);
      check("idle_gray", gray_w, 0);
      check("idle_tc", tc_w, 0);
    end

    for (int k = 0; k < 400; k++) begin
      tick4(($urandom_range(31) == 0), ($urandom_range(7) == 0), 4'($urandom),
            ($urandom_range(3) != 0), 1'($urandom));
    end

    tick8(1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 1000; k++) begin
      tick8(($urandom_range(63) == 0), ($urandom_range(7) == 0), 8'($urandom),
            ($urandom_range(3) != 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
